// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: N-digit time-multiplexed seven-segment display driver.
// Define SSD_LZ_BLANK_EN to blank leading zeros on digits above digit 0.
module ssd_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_BITS   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              data_in,
  input  logic [NUM_DIGITS-1:0]   load_btn,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic [4*NUM_DIGITS-1:0] digit_q
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0] btn_s1;
  logic [NUM_DIGITS-1:0] btn_s2;
  logic [NUM_DIGITS-1:0] btn_s3;
  logic [NUM_DIGITS-1:0] wr;
  logic [3:0]            dat_s1;
  logic [3:0]            dat_s2;
  logic [DIV_BITS-1:0]   pre;
  logic [IDX_W-1:0]      idx;
  logic [3:0]            cur;
  logic                  blank;
  logic [6:0]            seg_d;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      btn_s3 <= '0;
      dat_s1 <= '0;
      dat_s2 <= '0;
    end else begin
      btn_s1 <= load_btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
      dat_s1 <= data_in;
      dat_s2 <= dat_s1;
    end
  end

  // One-cycle strobe per press; a held button stays high in s2 and s3
  assign wr = btn_s2 & ~btn_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr[i]) digit_q[4*i +: 4] <= dat_s2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= pre + DIV_BITS'(1);
      if (&pre) idx <= (idx == LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  assign cur = digit_q[{idx, 2'b00} +: 4];

`ifdef SSD_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;

  // lz[i]: digit i and every digit above it are zero
  always_comb begin
    lz = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lz[i] = ((digit_q >> (4*i)) == '0);
    end
  end

  assign blank = (idx != '0) & lz[idx];
`else
  assign blank = 1'b0;
`endif

  assign seg_d = blank ? 7'h7F : decode(cur);

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= 7'h7F;
      an  <= '1;
    end else begin
      seg <= seg_d;
      an  <= ~(NUM_DIGITS'(1) << idx);
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// tb_ssd_scan_mux: directed and randomized checks of ssd_scan_mux
// against a cycle-count based reference model.
module tb_ssd_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  data_in;
  logic [3:0]  load_btn;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [15:0] digit_q;
  logic [6:0]  seg3;
  logic [2:0]  an3;
  logic        dp3;
  logic [11:0] digit_q3;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] DEC [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [3:0] AN_SEQ [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  localparam logic [2:0] AN3_SEQ [3] = '{3'h6, 3'h5, 3'h3};

  ssd_scan_mux #(.NUM_DIGITS(4), .DIV_BITS(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in),
    .load_btn(load_btn), .seg(seg), .an(an),
    .dp(dp), .digit_q(digit_q)
  );

  ssd_scan_mux #(.NUM_DIGITS(3), .DIV_BITS(1)) dut3 (
    .clk(clk), .rst(rst), .data_in(data_in),
    .load_btn(load_btn[2:0]), .seg(seg3), .an(an3),
    .dp(dp3), .digit_q(digit_q3)
  );

  always #5 clk = ~clk;

  // Reference model: digit values plus sampled input history
  logic [3:0]  mdig [4];
  logic [3:0]  bh [3];
  logic [3:0]  dh [3];
  int          cyc;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic [15:0] exp_dq;

  function automatic logic [6:0] ref_seg(int k);
`ifdef SSD_LZ_BLANK_EN
    bit z = 1'b1;
    for (int j = k; j < 4; j++) if (mdig[j] != 4'h0) z = 1'b0;
    if (k > 0 && z) return 7'h7F;
`endif
    return DEC[mdig[k]];
  endfunction

  always @(posedge clk) begin
    int k;
    if (rst) begin
      for (int i = 0; i < 4; i++) mdig[i] = 4'h0;
      for (int i = 0; i < 3; i++) begin
        bh[i] = 4'h0;
        dh[i] = 4'h0;
      end
      cyc = 0;
      exp_an = 4'hF;
      exp_seg = 7'h7F;
    end else begin
      cyc++;
      k = ((cyc - 1) / 4) % 4;
      exp_an = ~(4'b1 << k);
      exp_seg = ref_seg(k);
      for (int i = 0; i < 4; i++) begin
        if (bh[1][i] && !bh[2][i]) mdig[i] = dh[1];
      end
      bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = load_btn;
      dh[2] = dh[1]; dh[1] = dh[0]; dh[0] = data_in;
    end
    exp_dq = {mdig[3], mdig[2], mdig[1], mdig[0]};
  end

  task automatic do_reset(int n);
    rst = 1'b1;
    load_btn = 4'h0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_in = 4'h0;
    load_btn = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
        errors++;
        $display("FAIL reset_out an %h seg %h dp %b want F 7F 1",
                 an, seg, dp);
      end
      checks++;
      if (digit_q !== 16'h0 || an3 !== 3'h7) begin
        errors++;
        $display("FAIL reset_state dq %h an3 %h want 0 7",
                 digit_q, an3);
      end
    end
    rst = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      checks++;
      if (an !== AN_SEQ[((c - 1) / 4) % 4]) begin
        errors++;
        $display("FAIL scan4 c%0d got %h want %h",
                 c, an, AN_SEQ[((c - 1) / 4) % 4]);
      end
      checks++;
      if (an3 !== AN3_SEQ[((c - 1) / 2) % 3]) begin
        errors++;
        $display("FAIL scan3 c%0d got %h want %h",
                 c, an3, AN3_SEQ[((c - 1) / 2) % 3]);
      end
      if (c == 1) begin
        checks++;
        if (seg !== 7'h40) begin
          errors++;
          $display("FAIL first_seg got %h want 40", seg);
        end
      end
    end
  endtask

  task automatic test_single_load();
    bit found = 1'b0;
    data_in = 4'hA;
    load_btn = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) load_btn = 4'h0;
      @(negedge clk);
      checks++;
      if (digit_q !== exp_dq || seg !== exp_seg) begin
        errors++;
        $display("FAIL load_lat dq %h seg %h want %h %h",
                 digit_q, seg, exp_dq, exp_seg);
      end
    end
    checks++;
    if (digit_q !== 16'h0A00) begin
      errors++;
      $display("FAIL single_load got %h want 0A00", digit_q);
    end
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (an === 4'hB) begin
        found = 1'b1;
        checks++;
        if (seg !== 7'h08) begin
          errors++;
          $display("FAIL seg_at_B got %h want 08", seg);
        end
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_B timeout an %h want B", an);
    end
  endtask

  task automatic test_multi_load();
    int hits = 0;
    do_reset(2);
    data_in = 4'h7;
    load_btn = 4'b1001;
    repeat (2) @(negedge clk);
    load_btn = 4'h0;
    repeat (4) @(negedge clk);
    checks++;
    if (digit_q !== 16'h7007) begin
      errors++;
      $display("FAIL multi_load got %h want 7007", digit_q);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an === 4'h7 || an === 4'hE) begin
        hits++;
        checks++;
        if (seg !== 7'h78) begin
          errors++;
          $display("FAIL multi_seg an %h got %h want 78", an, seg);
        end
      end
    end
    checks++;
    if (hits == 0) begin
      errors++;
      $display("FAIL multi_scan hits %0d want >0", hits);
    end
  endtask

  task automatic test_lz();
    logic [6:0] want;
    do_reset(2);
    data_in = 4'hA;
    load_btn = 4'b0010;
    repeat (2) @(negedge clk);
    load_btn = 4'h0;
    repeat (4) @(negedge clk);
    checks++;
    if (digit_q !== 16'h00A0) begin
      errors++;
      $display("FAIL lz_load got %h want 00A0", digit_q);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
`ifdef SSD_LZ_BLANK_EN
      want = (an === 4'h7 || an === 4'hB) ? 7'h7F :
             (an === 4'hD) ? 7'h08 : 7'h40;
`else
      want = (an === 4'hD) ? 7'h08 : 7'h40;
`endif
      checks++;
      if (seg !== want) begin
        errors++;
        $display("FAIL lz_seg an %h got %h want %h", an, seg, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an === 4'hB) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_wait timeout an %h want B", an);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (an !== 4'hF || digit_q !== 16'h0) begin
        errors++;
        $display("FAIL mid_rst an %h dq %h want F 0", an, digit_q);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (an !== 4'hE || seg !== 7'h40) begin
      errors++;
      $display("FAIL mid_restart an %h seg %h want E 40", an, seg);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++;
        $display("FAIL rnd_out %0d an %h seg %h want %h %h",
                 i, an, seg, exp_an, exp_seg);
      end
      checks++;
      if (digit_q !== exp_dq || dp !== 1'b1) begin
        errors++;
        $display("FAIL rnd_dq %0d got %h dp %b want %h 1",
                 i, digit_q, dp, exp_dq);
      end
      rst = ($urandom_range(0, 99) == 0);
      data_in = 4'($urandom);
      if ($urandom_range(0, 3) == 0) load_btn = 4'($urandom);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    data_in = 4'h0;
    load_btn = 4'h0;
    test_reset();
    test_single_load();
    test_multi_load();
    test_lz();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
